// File: rtl/reset_sequencer.sv
// Filters PLL lock, waits a fixed delay, then releases rst_n bits one by one in order.
// Optional macro RESET_SEQ_RELOCK_EN makes lock loss in RUN restart the sequence.
module reset_sequencer #(
  parameter int CHANNELS    = 2,
  parameter int LOCK_FILTER = 4,
  parameter int RESET_DELAY = 128,
  parameter int STAGE_GAP   = 16
) (
  input  logic                clk_core,
  input  logic                resetn,
  input  logic                pll_locked,
  output logic [CHANNELS-1:0] rst_n,
  output logic                ready,
  output logic [7:0]          relock_count
);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] DELAY     = 2'd1;
  localparam logic [1:0] RELEASE   = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  localparam logic [7:0]          FILT = 8'(LOCK_FILTER);
  localparam logic [15:0]         DLY  = 16'(RESET_DELAY);
  localparam logic [7:0]          GAP  = 8'(STAGE_GAP - 1);
  localparam logic [CHANNELS-1:0] ONE  = CHANNELS'(1);

  logic                sync1;
  logic                sync2;
  logic [1:0]          state;
  logic [7:0]          filt_cnt;
  logic [7:0]          filt_nxt;
  logic [7:0]          gap_cnt;
  logic [15:0]         dly_cnt;
  logic [CHANNELS-1:0] rst_q;
  logic [CHANNELS-1:0] rst_shift;
  logic                lose;
  logic                lose_run;

  always_comb begin
    filt_nxt = 8'd0;
    if (sync2) begin
      filt_nxt = (filt_cnt == FILT) ? filt_cnt : filt_cnt + 8'd1;
    end
  end

  // Shifting ones in from bit 0 makes out-of-order release impossible.
  assign rst_shift = (rst_q << 1) | ONE;

`ifdef RESET_SEQ_RELOCK_EN
  assign lose_run = !sync2 && (state == RUN);
`else
  assign lose_run = 1'b0;
`endif

  assign lose = (!sync2 && (state == DELAY || state == RELEASE)) || lose_run;

  always_ff @(posedge clk_core) begin
    if (!resetn) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      state        <= WAIT_LOCK;
      filt_cnt     <= 8'd0;
      gap_cnt      <= 8'd0;
      dly_cnt      <= 16'd0;
      rst_q        <= '0;
      relock_count <= 8'd0;
    end else begin
      sync1    <= pll_locked;
      sync2    <= sync1;
      filt_cnt <= filt_nxt;
      if (lose) begin
        state   <= WAIT_LOCK;
        rst_q   <= '0;
        dly_cnt <= 16'd0;
        gap_cnt <= 8'd0;
        if (lose_run && relock_count != 8'hFF) begin
          relock_count <= relock_count + 8'd1;
        end
      end else begin
        case (state)
          WAIT_LOCK: begin
            if (filt_nxt == FILT) begin
              state   <= DELAY;
              dly_cnt <= 16'd0;
            end
          end
          DELAY: begin
            if (dly_cnt == DLY) begin
              rst_q   <= ONE;
              gap_cnt <= 8'd0;
              state   <= (CHANNELS == 1) ? RUN : RELEASE;
            end else begin
              dly_cnt <= dly_cnt + 16'd1;
            end
          end
          RELEASE: begin
            if (gap_cnt == GAP) begin
              rst_q   <= rst_shift;
              gap_cnt <= 8'd0;
              if (&rst_shift) state <= RUN;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  assign rst_n = rst_q;
  assign ready = &rst_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: rst_n transitions are predicted into a scoreboard queue and checked as they occur.
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       resetn;
  logic       lock;
  logic       lock2;
  logic [1:0] rst_n;
  logic       ready;
  logic [7:0] relock_count;
  logic [3:0] rst_n2;
  logic       ready2;
  logic [7:0] relock2;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  typedef struct {
    int         e;
    logic [1:0] v;
    logic       r;
  } ev_t;
  ev_t q[$];
  logic [1:0] prev;

  reset_sequencer dut (
    .clk_core(clk), .resetn(resetn), .pll_locked(lock),
    .rst_n(rst_n), .ready(ready), .relock_count(relock_count)
  );

  reset_sequencer #(.CHANNELS(4), .LOCK_FILTER(1), .RESET_DELAY(1), .STAGE_GAP(1)) dut2 (
    .clk_core(clk), .resetn(resetn), .pll_locked(lock2),
    .rst_n(rst_n2), .ready(ready2), .relock_count(relock2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic push(input int e, input logic [1:0] v, input logic r);
    ev_t ev;
    ev.e = e;
    ev.v = v;
    ev.r = r;
    q.push_back(ev);
  endtask

  task automatic cyc(input int n);
    ev_t ev;
    repeat (n) begin
      @(negedge clk);
      if (rst_n !== prev) begin
        chk("sb_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          ev = q.pop_front();
          chk("sb_edge", 32'(edge_n), 32'(ev.e));
          chk("sb_rst_n", 32'(rst_n), 32'(ev.v));
          chk("sb_ready", 32'(ready), 32'(ev.r));
        end
        prev = rst_n;
      end
    end
  endtask

  initial begin
    int g;
    int n;
    int d;
    int r;
    int x;
    int m;
    int exp_relock;
    resetn = 1'b0;
    lock   = 1'b0;
    lock2  = 1'b0;
    prev   = 2'b00;
    cyc(3);
    chk("reset_rst_n", 32'(rst_n), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_relock", 32'(relock_count), 32'd0);
    chk("reset_rst_n2", 32'(rst_n2), 32'd0);
    resetn = 1'b1;
    cyc(5);
    chk("idle_rst_n", 32'(rst_n), 32'd0);

    // Glitch: 3 highs, 1 low, then steady high from edge n.
    lock = 1'b1;
    g = edge_n + 1;
    cyc(3);
    lock = 1'b0;
    cyc(1);
    lock = 1'b1;
    n = edge_n + 1;
    chk("glitch_start", 32'(n), 32'(g + 4));
    push(n + 134, 2'b01, 1'b0);
    push(n + 150, 2'b11, 1'b1);
    cyc(6);
    chk("glitch_rst_n", 32'(rst_n), 32'd0);
    cyc(n + 160 - edge_n);
    chk("run_rst_n", 32'(rst_n), 32'd3);
    chk("run_ready", 32'(ready), 32'd1);
    chk("run_relock", 32'(relock_count), 32'd0);

    // Three lock losses while in RUN.
    for (int i = 0; i < 3; i++) begin
      lock = 1'b0;
      d = edge_n + 1;
`ifdef RESET_SEQ_RELOCK_EN
      push(d + 2, 2'b00, 1'b0);
`endif
      cyc(10);
      lock = 1'b1;
      r = edge_n + 1;
`ifdef RESET_SEQ_RELOCK_EN
      push(r + 134, 2'b01, 1'b0);
      push(r + 150, 2'b11, 1'b1);
`endif
      cyc(r + 160 - edge_n);
      chk("relock_rst_n", 32'(rst_n), 32'd3);
    end
`ifdef RESET_SEQ_RELOCK_EN
    exp_relock = 3;
`else
    exp_relock = 0;
`endif
    chk("relock_count", 32'(relock_count), 32'(exp_relock));

    // One-cycle resetn pulse in RUN, lock held high.
    resetn = 1'b0;
    x = edge_n + 1;
    push(x, 2'b00, 1'b0);
    cyc(1);
    chk("pulse_rst_n", 32'(rst_n), 32'd0);
    chk("pulse_ready", 32'(ready), 32'd0);
    chk("pulse_relock", 32'(relock_count), 32'd0);
    resetn = 1'b1;
    push(x + 135, 2'b01, 1'b0);
    push(x + 151, 2'b11, 1'b1);
    cyc(x + 160 - edge_n);

    // Lock lost during RELEASE (rst_n = 01).
    resetn = 1'b0;
    x = edge_n + 1;
    push(x, 2'b00, 1'b0);
    cyc(1);
    resetn = 1'b1;
    push(x + 135, 2'b01, 1'b0);
    cyc(x + 140 - edge_n);
    lock = 1'b0;
    push(x + 143, 2'b00, 1'b0);
    cyc(5);
    chk("drop_rst_n", 32'(rst_n), 32'd0);
    chk("drop_relock", 32'(relock_count), 32'd0);
    lock = 1'b1;
    r = edge_n + 1;
    push(r + 134, 2'b01, 1'b0);
    push(r + 150, 2'b11, 1'b1);
    cyc(r + 160 - edge_n);
    chk("sb_drained", 32'(q.size()), 32'd0);

    // Four channels released on consecutive edges.
    lock2 = 1'b1;
    m = edge_n + 1;
    cyc(m + 3 - edge_n);
    chk("ch4_pre", 32'(rst_n2), 32'h0);
    cyc(1);
    chk("ch4_s1", 32'({ready2, rst_n2}), 32'h01);
    cyc(1);
    chk("ch4_s2", 32'({ready2, rst_n2}), 32'h03);
    cyc(1);
    chk("ch4_s3", 32'({ready2, rst_n2}), 32'h07);
    cyc(1);
    chk("ch4_s4", 32'({ready2, rst_n2}), 32'h1F);
    cyc(5);
    chk("ch4_hold", 32'({ready2, rst_n2}), 32'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of sequenced reset outputs, range 1..8.
REQ-002 SHALL have parameter LOCK_FILTER, default 4: consecutive synchronised-lock cycles required before lock is trusted, range 1..255.
REQ-003 SHALL have parameter RESET_DELAY, default 128: cycles held in reset after trusted lock, before channel 0 is released, range 1..65535.
REQ-004 SHALL have parameter STAGE_GAP, default 16: cycles between release of channel k and channel k+1, range 1..255.
REQ-005 SHALL have port clk_core, input, 1: the single clock for all logic.
REQ-006 SHALL have port resetn, input, 1: synchronous, active-low reset, sampled on rising clk_core.
REQ-007 SHALL have port pll_locked, input, 1: asynchronous lock indication from the PLL.
REQ-008 SHALL have port rst_n, output, CHANNELS: active-low per-domain resets; bit 0 is released first.
REQ-009 SHALL have port ready, output, 1: high when every rst_n bit is high.
REQ-010 SHALL have port relock_count, output, 8: saturating count of lock losses seen in RUN.

Function
REQ-011 SHALL pass pll_locked through a 2-flop synchroniser; only the synchronised value is used downstream.
REQ-012 SHALL keep a lock filter counter that increments while synchronised lock is 1, clears to 0 in any cycle it is 0, and saturates at LOCK_FILTER.
REQ-013 SHALL implement states WAIT_LOCK, DELAY, RELEASE and RUN.
REQ-014 WAIT_LOCK SHALL move to DELAY on the edge where the filter counter reaches LOCK_FILTER.
REQ-015 DELAY SHALL count RESET_DELAY cycles, then on the next edge drive rst_n[0] high and enter RELEASE.
REQ-016 RELEASE SHALL drive the next rst_n bit high every STAGE_GAP cycles. On the edge releasing bit CHANNELS-1 it SHALL enter RUN, with ready rising on that same edge.
REQ-017 When CHANNELS=1, the DELAY exit edge SHALL go directly to RUN.
REQ-018 Released bits SHALL stay high in RELEASE and RUN. Bits SHALL never be released out of order.
REQ-019 rst_n[0] SHALL rise exactly SYNC(2)+LOCK_FILTER+RESET_DELAY edges after the first edge sampling pll_locked=1, provided lock stays high throughout.
REQ-020 Synchronised lock dropping to 0 in DELAY or RELEASE SHALL, on the next edge, drive all rst_n low and ready low, and return to WAIT_LOCK with the counters cleared.
REQ-021 Lock loss in RUN is governed by REQ-026/REQ-027. relock_count SHALL increment by 1 per RUN-state loss and hold at 255.
REQ-022 A lock glitch shorter than LOCK_FILTER cycles in WAIT_LOCK SHALL restart filtering from 0.

Reset
REQ-023 With resetn=0 at an edge, the block SHALL set: all rst_n=0, ready=0, relock_count=0, state=WAIT_LOCK, filter, delay and gap counters=0, and synchroniser flops=0.
REQ-024 resetn asserted mid-DELAY, RELEASE or RUN SHALL take effect on that same edge.
REQ-025 After resetn deasserts, the full REQ-019 latency SHALL apply again.

Configuration
REQ-026 With macro RESET_SEQ_RELOCK_EN defined, lock loss in RUN SHALL behave as REQ-020: all resets reasserted, WAIT_LOCK re-entered, and relock_count incremented.
REQ-027 Without RESET_SEQ_RELOCK_EN, RUN SHALL be sticky: lock loss SHALL be ignored, rst_n and ready SHALL stay high, and relock_count SHALL stay 0.

Verification
REQ-028 Defaults; pll_locked=1 from edge N -> rst_n[0] rises at N+134, rst_n[1] and ready rise at N+150, relock_count=0.
REQ-029 Defaults; pll_locked high 3 cycles, low 1 cycle, then high -> no DELAY entry until 4 consecutive synchronised highs; rst_n stays 2'b00 during the glitch.
REQ-030 Defaults; lock drops at N+140 (rst_n=2'b01) -> rst_n=2'b00 by the second edge after the synchronised drop; sequence restarts from WAIT_LOCK.
REQ-031 With RESET_SEQ_RELOCK_EN, lock dropped in RUN 3 times with relock between each -> relock_count=3, and each relock yields a full 134/150 release. Without the macro: rst_n stays 2'b11 and relock_count=0.
REQ-032 resetn=0 for 1 cycle at N+145 -> same edge: rst_n=0, ready=0; release recurs 134 edges after resetn returns high.
REQ-033 CHANNELS=4, STAGE_GAP=1 -> rst_n goes 0001, 0011, 0111, 1111 on consecutive edges, with ready on the last.
